matmul_out_serializer: RTL and testbench
========================================

MATMUL_OUT_SERIALIZER -- requirements
Module: matmul_out_serializer

Interface
REQ-001 SHALL have parameter X_ROWS, default 4, rows per result tile.
REQ-002 SHALL have parameter Y_COLS, default 2, columns per result tile.
REQ-003 SHALL have parameter IN_WIDTH, default 32, signed accumulator width of the incoming result.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed width of the streamed element (OUT_WIDTH <= IN_WIDTH).
REQ-005 SHALL have parameter SCALE_WIDTH, default 8, shared-scale width.
REQ-006 SHALL have port i_clk  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_valid  input  1  result tile on i_C/i_S_C is valid.
REQ-009 SHALL have port o_ready  output  1  block accepts a tile this cycle.
REQ-010 SHALL have port i_C  input  signed [IN_WIDTH-1:0] x [X_ROWS][Y_COLS]  result tile from the matmul stage.
REQ-011 SHALL have port i_S_C  input  [SCALE_WIDTH-1:0] x [X_ROWS][Y_COLS]  per-element result scales.
REQ-012 SHALL have port o_valid  output  1  streamed element valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts element.
REQ-014 SHALL have port o_data  output  signed OUT_WIDTH  element value.
REQ-015 SHALL have port o_scale  output  SCALE_WIDTH  element scale.
REQ-016 SHALL have ports o_row / o_col  output  clog2(X_ROWS) / clog2(Y_COLS) (min 1)  element coordinates.
REQ-017 SHALL have port o_last  output  1  final element of the tile.
REQ-018 SHALL have port o_sat  output  1  element was clipped (REQ-033).

Function
REQ-019 SHALL implement FSM states IDLE and STREAM.
REQ-020 IDLE: o_ready=1, o_valid=0; i_valid=1 SHALL capture all of i_C and i_S_C into an internal tile buffer and move to STREAM with index (0,0).
REQ-021 STREAM: o_valid SHALL be 1 and present the buffered element at (o_row,o_col), in row-major order.
REQ-022 Latency SHALL be exactly one cycle from capture edge to o_valid=1 for element (0,0).
REQ-023 An element SHALL advance only on o_valid&&i_ready; col increments, wrapping to 0 with row increment at Y_COLS-1.
REQ-024 While o_valid&&!i_ready, o_data, o_scale, o_row, o_col, o_last, o_sat SHALL hold stable.
REQ-025 o_last SHALL be 1 only at (X_ROWS-1, Y_COLS-1).
REQ-026 STREAM: o_ready SHALL equal o_last&&i_ready (combinational), allowing back-to-back tiles with no bubble.
REQ-027 Last element accepted with i_valid=1: SHALL capture the new tile and stay in STREAM at index (0,0).
REQ-028 Last element accepted with i_valid=0: SHALL return to IDLE.
REQ-029 i_valid while o_ready=0 SHALL be ignored; buffer unchanged; upstream holds the tile.
REQ-030 Sustained throughput SHALL be X_ROWS*Y_COLS elements per tile with i_ready held high.

Reset
REQ-031 i_rst_n low SHALL immediately force IDLE, index (0,0), o_valid=0, o_last=0, o_sat=0, o_row=o_col=0; o_data/o_scale SHALL read 0.
REQ-032 Reset mid-STREAM SHALL discard the partial tile; after release, o_ready=1 and no element is re-emitted.

Configuration
REQ-033 Macro MATMUL_OUT_SAT_EN defined: o_data SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], o_sat=1 when clipped, else 0.
REQ-034 Macro MATMUL_OUT_SAT_EN undefined: o_data SHALL be the low OUT_WIDTH bits of the element (two's-complement wrap), o_sat tied 0; port list unchanged.

Verification
REQ-035 Defaults; tile i_C[r][c]=10*r+c, scales 100+r*2+c, i_ready=1 -> 8 elements 0,1,10,11,20,21,30,31 on consecutive cycles starting 1 cycle after capture, o_last only on 31.
REQ-036 i_ready toggling 1,0,0,1,... -> no element lost or duplicated; outputs stable across stalls.
REQ-037 Second tile presented with i_valid on last-element cycle -> its element (0,0) on next cycle, no gap; i_valid mid-tile -> ignored until then.
REQ-038 MATMUL_OUT_SAT_EN defined, i_C element 40000 and -40000 -> o_data 32767/-32768, o_sat=1; undefined -> -25536/25536, o_sat=0.
REQ-039 i_rst_n asserted at element 3 -> o_valid falls asynchronously; after release o_ready=1 and fresh tile streams from (0,0).

Source files
------------

// File: rtl/matmul_out_serializer.sv
// Matmul result serializer: buffers one X_ROWS x Y_COLS tile and streams it row-major
// with valid/ready. Optional output clipping enabled by `define MATMUL_OUT_SAT_EN.
module matmul_out_serializer #(
    parameter int unsigned X_ROWS      = 4,
    parameter int unsigned Y_COLS      = 2,
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SCALE_WIDTH = 8,
    localparam int unsigned ROW_W      = (X_ROWS > 1) ? $clog2(X_ROWS) : 1,
    localparam int unsigned COL_W      = (Y_COLS > 1) ? $clog2(Y_COLS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [IN_WIDTH-1:0]    i_C   [X_ROWS][Y_COLS],
    input  logic        [SCALE_WIDTH-1:0] i_S_C [X_ROWS][Y_COLS],
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [OUT_WIDTH-1:0]   o_data,
    output logic        [SCALE_WIDTH-1:0] o_scale,
    output logic        [ROW_W-1:0]       o_row,
    output logic        [COL_W-1:0]       o_col,
    output logic                          o_last,
    output logic                          o_sat
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [IN_WIDTH-1:0]    c_buf [X_ROWS][Y_COLS];
    logic        [SCALE_WIDTH-1:0] s_buf [X_ROWS][Y_COLS];

    logic                          accept;
    logic                          capture;
    logic                          load;
    logic                          go_idle;
    logic        [ROW_W-1:0]       row_nxt;
    logic        [COL_W-1:0]       col_nxt;
    logic                          last_nxt;
    logic signed [IN_WIDTH-1:0]    elem_nxt;
    logic        [SCALE_WIDTH-1:0] scale_nxt;
    logic signed [OUT_WIDTH-1:0]   data_nxt;
    logic                          sat_nxt;

`ifdef MATMUL_OUT_SAT_EN
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`else
    // Wrap mode only keeps the low OUT_WIDTH bits of each element.
    logic unused_hi;
    assign unused_hi = ^elem_nxt;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = STREAM;
            STREAM:  if (go_idle) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake decode, next element index and next element value
    always_comb begin
        o_ready   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        load      = 1'b0;
        go_idle   = 1'b0;
        row_nxt   = o_row;
        col_nxt   = o_col;
        last_nxt  = 1'b0;
        elem_nxt  = '0;
        scale_nxt = '0;
        data_nxt  = '0;
        sat_nxt   = 1'b0;

        case (state)
            IDLE: begin
                o_ready = 1'b1;
            end
            STREAM: begin
                accept  = i_ready;
                o_ready = o_last && i_ready;
            end
            default: ;
        endcase

        capture = i_valid && o_ready;
        load    = capture || (accept && !o_last);
        go_idle = accept && o_last && !capture;

        if (capture) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (o_col == COL_W'(Y_COLS - 1)) begin
            col_nxt = '0;
            row_nxt = o_row + ROW_W'(1);
        end else begin
            col_nxt = o_col + COL_W'(1);
        end

        last_nxt = (row_nxt == ROW_W'(X_ROWS - 1)) && (col_nxt == COL_W'(Y_COLS - 1));

        // A freshly captured tile is presented straight from the input ports.
        if (capture) begin
            elem_nxt  = i_C[0][0];
            scale_nxt = i_S_C[0][0];
        end else begin
            elem_nxt  = c_buf[row_nxt][col_nxt];
            scale_nxt = s_buf[row_nxt][col_nxt];
        end

        data_nxt = OUT_WIDTH'(elem_nxt);
`ifdef MATMUL_OUT_SAT_EN
        if (elem_nxt > SAT_MAX) begin
            data_nxt = OUT_WIDTH'(SAT_MAX);
            sat_nxt  = 1'b1;
        end else if (elem_nxt < SAT_MIN) begin
            data_nxt = OUT_WIDTH'(SAT_MIN);
            sat_nxt  = 1'b1;
        end
`endif
    end

    // Tile buffer and registered element outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < int'(X_ROWS); r++) begin
                for (int c = 0; c < int'(Y_COLS); c++) begin
                    c_buf[r][c] <= '0;
                    s_buf[r][c] <= '0;
                end
            end
            o_valid <= 1'b0;
            o_data  <= '0;
            o_scale <= '0;
            o_row   <= '0;
            o_col   <= '0;
            o_last  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            if (capture) begin
                c_buf <= i_C;
                s_buf <= i_S_C;
            end

            o_valid <= (state_next == STREAM);

            if (load) begin
                o_row   <= row_nxt;
                o_col   <= col_nxt;
                o_last  <= last_nxt;
                o_data  <= data_nxt;
                o_scale <= scale_nxt;
                o_sat   <= sat_nxt;
            end else if (go_idle) begin
                o_row   <= '0;
                o_col   <= '0;
                o_last  <= 1'b0;
                o_data  <= '0;
                o_scale <= '0;
                o_sat   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_out_serializer.sv
// Self-checking bench for matmul_out_serializer: vector table, directed sequences and
// randomized traffic scored against a queue-based reference. Honours MATMUL_OUT_SAT_EN.
module tb_matmul_out_serializer;

    localparam int X  = 4;
    localparam int Y  = 2;
    localparam int IW = 32;
    localparam int OW = 16;
    localparam int SW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_valid;
    logic                 o_ready;
    logic signed [IW-1:0] c_in [X][Y];
    logic        [SW-1:0] s_in [X][Y];
    logic                 o_valid;
    logic                 i_ready;
    logic signed [OW-1:0] o_data;
    logic        [SW-1:0] o_scale;
    logic        [1:0]    o_row;
    logic        [0:0]    o_col;
    logic                 o_last;
    logic                 o_sat;

    matmul_out_serializer #(
        .X_ROWS(X), .Y_COLS(Y), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SCALE_WIDTH(SW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_C    (c_in),
        .i_S_C  (s_in),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_scale(o_scale),
        .o_row  (o_row),
        .o_col  (o_col),
        .o_last (o_last),
        .o_sat  (o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int scale;
        int row;
        int col;
        bit last;
        bit sat;
    } elem_t;

    typedef struct {
        longint val;
        int     wrap_data;
        int     sat_data;
        bit     clipped;
    } vec_t;

    elem_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    captured;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: clamp to the signed output range, or wrap modulo 2^OW.
    function automatic int ref_data(input longint v);
        longint half = longint'(1) << (OW - 1);
        longint full = longint'(1) << OW;
        longint m;
`ifdef MATMUL_OUT_SAT_EN
        if (v > half - 1) return int'(half - 1);
        if (v < -half) return int'(-half);
        return int'(v);
`else
        m = ((v % full) + full) % full;
        return (m >= half) ? int'(m - full) : int'(m);
`endif
    endfunction

    function automatic bit ref_sat(input longint v);
`ifdef MATMUL_OUT_SAT_EN
        longint half = longint'(1) << (OW - 1);
        return (v > half - 1) || (v < -half);
`else
        return (v != v);
`endif
    endfunction

    task automatic push_tile();
        elem_t e;
        for (int r = 0; r < X; r++) begin
            for (int c = 0; c < Y; c++) begin
                e.data  = ref_data(longint'(c_in[r][c]));
                e.scale = int'(s_in[r][c]);
                e.row   = r;
                e.col   = c;
                e.last  = (r == X - 1) && (c == Y - 1);
                e.sat   = ref_sat(longint'(c_in[r][c]));
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at a falling edge with inputs already driven for the next rising edge.
    task automatic tick();
        bit    exp_ready;
        elem_t e;
        #1;
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && i_ready);
        chk("o_valid", longint'(o_valid), longint'(exp_q.size() != 0));
        chk("o_ready", longint'(o_ready), longint'(exp_ready));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("o_data",  longint'(o_data),  longint'(e.data));
            chk("o_scale", longint'(o_scale), longint'(e.scale));
            chk("o_row",   longint'(o_row),   longint'(e.row));
            chk("o_col",   longint'(o_col),   longint'(e.col));
            chk("o_last",  longint'(o_last),  longint'(e.last));
            chk("o_sat",   longint'(o_sat),   longint'(e.sat));
            if (i_ready) void'(exp_q.pop_front());
        end else begin
            chk("idle_data", longint'(o_data), 0);
            chk("idle_last", longint'(o_last), 0);
            chk("idle_sat",  longint'(o_sat),  0);
        end
        captured = i_valid && exp_ready;
        if (captured) push_tile();
        @(negedge clk);
    endtask

    task automatic fill_pattern(input int base);
        for (int r = 0; r < X; r++) begin
            for (int c = 0; c < Y; c++) begin
                c_in[r][c] = IW'(base + 10 * r + c);
                s_in[r][c] = SW'(100 + 2 * r + c);
            end
        end
    endtask

    task automatic fill_random();
        int v;
        for (int r = 0; r < X; r++) begin
            for (int c = 0; c < Y; c++) begin
                if ($urandom_range(0, 3) == 0) v = int'($urandom);
                else v = int'($urandom_range(0, 80000)) - 40000;
                c_in[r][c] = v;
                s_in[r][c] = SW'($urandom);
            end
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) tick();
        chk("drain_left", longint'(exp_q.size()), 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   exp35[8];
        int   n;

        vecs[0] = '{val: 0,      wrap_data: 0,      sat_data: 0,      clipped: 1'b0};
        vecs[1] = '{val: 32767,  wrap_data: 32767,  sat_data: 32767,  clipped: 1'b0};
        vecs[2] = '{val: 32768,  wrap_data: -32768, sat_data: 32767,  clipped: 1'b1};
        vecs[3] = '{val: -32768, wrap_data: -32768, sat_data: -32768, clipped: 1'b0};
        vecs[4] = '{val: -32769, wrap_data: 32767,  sat_data: -32768, clipped: 1'b1};
        vecs[5] = '{val: 40000,  wrap_data: -25536, sat_data: 32767,  clipped: 1'b1};
        vecs[6] = '{val: -40000, wrap_data: 25536,  sat_data: -32768, clipped: 1'b1};
        vecs[7] = '{val: -1,     wrap_data: -1,     sat_data: -1,     clipped: 1'b0};
        vecs[8] = '{val: 65541,  wrap_data: 5,      sat_data: 32767,  clipped: 1'b1};
        exp35   = '{0, 1, 10, 11, 20, 21, 30, 31};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        fill_pattern(0);
        #1;
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_ready", longint'(o_ready), 1);
        chk("rst_data",  longint'(o_data),  0);
        chk("rst_scale", longint'(o_scale), 0);
        chk("rst_row",   longint'(o_row),   0);
        chk("rst_last",  longint'(o_last),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reference tile with i_ready held high: 8 elements on consecutive cycles
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("seq_valid", longint'(o_valid), 1);
            chk("seq_data",  longint'(o_data),  longint'(exp35[k]));
            chk("seq_last",  longint'(o_last),  longint'(k == 7));
            tick();
        end
        chk("seq_end_valid", longint'(o_valid), 0);

        // Stall pattern 1,0,0,1 repeating
        fill_pattern(500);
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            i_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        drain();

        // Second tile offered mid-tile: held until the last-element cycle, then no gap
        fill_pattern(0);
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        fill_pattern(1000);
        captured = 1'b0;
        n = 0;
        while (!captured && n < 32) begin
            tick();
            n++;
        end
        chk("b2b_wait", longint'(n), 8);
        i_valid = 1'b0;
        chk("b2b_valid", longint'(o_valid), 1);
        chk("b2b_data",  longint'(o_data),  1000);
        chk("b2b_row",   longint'(o_row),   0);
        drain();

        // Conversion corner values at element (0,0)
        for (int i = 0; i < 9; i++) begin
            fill_pattern(0);
            c_in[0][0] = IW'(vecs[i].val);
            i_valid = 1'b1;
            i_ready = 1'b1;
            tick();
            i_valid = 1'b0;
`ifdef MATMUL_OUT_SAT_EN
            chk("vec_data", longint'(o_data), longint'(vecs[i].sat_data));
            chk("vec_sat",  longint'(o_sat),  longint'(vecs[i].clipped));
`else
            chk("vec_data", longint'(o_data), longint'(vecs[i].wrap_data));
            chk("vec_sat",  longint'(o_sat),  0);
`endif
            drain();
        end

        // Reset while element 3 is presented
        fill_pattern(0);
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        chk("pre_rst_row", longint'(o_row), 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", longint'(o_valid), 0);
        chk("arst_ready", longint'(o_ready), 1);
        chk("arst_data",  longint'(o_data),  0);
        chk("arst_row",   longint'(o_row),   0);
        chk("arst_col",   longint'(o_col),   0);
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (2) tick();
        fill_pattern(200);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("post_rst_data", longint'(o_data), 200);
        drain();

        // Randomized traffic; tile contents change every cycle while not accepted
        for (int k = 0; k < 1500; k++) begin
            fill_random();
            i_valid = ($urandom_range(0, 1) == 1);
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
